// File: rtl/q3c_fsm_pkg.sv
// Shared types and helpers for the q3c 5-state Moore machine.
// Holds state encoding, next-state, output decode and legality check.
package q3c_fsm_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } q3c_state_e;

  localparam logic [2:0] MAX_LEGAL = 3'b100;

  function automatic logic is_legal(input logic [2:0] code);
    return code <= MAX_LEGAL;
  endfunction

  // Illegal codes fall back to S0 so nothing outside S0..S4 escapes.
  function automatic q3c_state_e next_state(
    input q3c_state_e s,
    input logic       x
  );
    q3c_state_e n;
    n = S0;
    case (s)
      S0:      n = x ? S1 : S0;
      S1:      n = x ? S4 : S1;
      S2:      n = x ? S1 : S2;
      S3:      n = x ? S2 : S1;
      S4:      n = x ? S4 : S3;
      default: n = S0;
    endcase
    return n;
  endfunction

  function automatic logic z_of(input q3c_state_e s);
    return (s == S3) || (s == S4);
  endfunction

endpackage

// File: rtl/q3c_fsm_ch.sv
// One q3c channel: state register, sticky illegal-load flag, z counter.
// Ports: clk, reset, en, x, load, load_state, err_clr, cnt_clr -> state, z, err, z_count.
module q3c_fsm_ch
  import q3c_fsm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [2:0]       load_state,
  input  logic             err_clr,
  input  logic             cnt_clr,
  output logic [2:0]       state,
  output logic             z,
  output logic             err,
  output logic [CNT_W-1:0] z_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  q3c_state_e       state_q, state_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    z_now   = z_of(state_q);

    // Set beats clear when both hit the same cycle.
    if (err_clr) err_d = 1'b0;

    if (load) begin
      if (is_legal(load_state)) begin
        state_d = q3c_state_e'(load_state);
      end else begin
        state_d = S0;
        err_d   = 1'b1;
      end
    end else if (en) begin
      state_d = next_state(state_q, x);
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (z_now && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign state   = state_q;
  assign z       = z_now;
  assign err     = err_q;
  assign z_count = cnt_q;

endmodule

// File: rtl/q3c_fsm_bank.sv
// Bank of NUM_CH independent q3c channels on one clock.
// Slices the per-channel buses and fans err_clr out to every channel.
module q3c_fsm_bank
  import q3c_fsm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       x,
  input  logic [NUM_CH-1:0]       load,
  input  logic [3*NUM_CH-1:0]     load_state,
  input  logic                    err_clr,
  input  logic [NUM_CH-1:0]       cnt_clr,
  output logic [3*NUM_CH-1:0]     state,
  output logic [NUM_CH-1:0]       z,
  output logic [NUM_CH-1:0]       err,
  output logic [CNT_W*NUM_CH-1:0] z_count
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    q3c_fsm_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .en        (en[i]),
      .x         (x[i]),
      .load      (load[i]),
      .load_state(load_state[3*i +: 3]),
      .err_clr   (err_clr),
      .cnt_clr   (cnt_clr[i]),
      .state     (state[3*i +: 3]),
      .z         (z[i]),
      .err       (err[i]),
      .z_count   (z_count[CNT_W*i +: CNT_W])
    );
  end

endmodule

// File: tb/tb_q3c_fsm_bank.sv
// Self-checking bench for q3c_fsm_bank: directed vectors then random run.
// Uses NUM_CH=4, CNT_W=2 so counter saturation is reached quickly.
module tb_q3c_fsm_bank;

  localparam int NC = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   en, x, load, cnt_clr;
  logic [3*NC-1:0] load_state;
  logic            err_clr;
  logic [3*NC-1:0] state;
  logic [NC-1:0]   z, err;
  logic [CW*NC-1:0] z_count;

  int checks = 0;
  int errors = 0;

  logic [2:0]    ms [NC];
  logic          me [NC];
  logic [CW-1:0] mc [NC];

  q3c_fsm_bank #(
    .NUM_CH(NC),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .x         (x),
    .load      (load),
    .load_state(load_state),
    .err_clr   (err_clr),
    .cnt_clr   (cnt_clr),
    .state     (state),
    .z         (z),
    .err       (err),
    .z_count   (z_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] tnext(input logic [2:0] s,
                                        input logic x_i);
    case (s)
      3'd0:    return x_i ? 3'd1 : 3'd0;
      3'd1:    return x_i ? 3'd4 : 3'd1;
      3'd2:    return x_i ? 3'd1 : 3'd2;
      3'd3:    return x_i ? 3'd2 : 3'd1;
      3'd4:    return x_i ? 3'd4 : 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  task automatic idle();
    reset = 1'b0; en = '0; x = '0; load = '0;
    load_state = '0; err_clr = 1'b0; cnt_clr = '0;
  endtask

  initial begin
    logic [2:0]  s0exp [5];
    logic        z0exp [5];
    logic        x0seq [5];
    logic [CW-1:0] cexp [6];
    logic [3*NC-1:0] es;
    logic [NC-1:0]   ez, ee;
    logic [CW*NC-1:0] ec;
    logic [2:0] ls;
    logic       bad;

    s0exp = '{3'd1, 3'd4, 3'd3, 3'd1, 3'd4};
    z0exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    x0seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    cexp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    idle();
    reset = 1'b1;
    tick();
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_z", 32'(z), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_cnt", 32'(z_count), 32'h0);
    reset = 1'b0;

    // ch0 walk
    en[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x[0] = x0seq[i];
      tick();
      chk($sformatf("ch0_st%0d", i), 32'(state[2:0]), 32'(s0exp[i]));
      chk($sformatf("ch0_z%0d", i), 32'(z[0]), 32'(z0exp[i]));
    end
    chk("ch1to3_idle", 32'(state[11:3]), 32'h0);
    en[0] = 1'b0;

    // ch1 load beats step
    load[1] = 1'b1; load_state[5:3] = 3'b011;
    en[1] = 1'b1; x[1] = 1'b1;
    tick();
    chk("ch1_load", 32'(state[5:3]), 32'd3);
    chk("ch1_z", 32'(z[1]), 32'd1);
    load[1] = 1'b0; x[1] = 1'b0;
    tick();
    chk("ch1_step", 32'(state[5:3]), 32'd1);
    en[1] = 1'b0;

    // ch2 illegal load and err priority
    load[2] = 1'b1; load_state[8:6] = 3'b110;
    tick();
    chk("ch2_ill_st", 32'(state[8:6]), 32'd0);
    chk("ch2_ill_err", 32'(err), 32'h4);
    err_clr = 1'b1;
    tick();
    chk("ch2_setwins", 32'(err[2]), 32'd1);
    load[2] = 1'b0;
    tick();
    chk("ch2_clr", 32'(err[2]), 32'd0);
    err_clr = 1'b0;

    // ch3 counter saturation
    load[3] = 1'b1; load_state[11:9] = 3'b100;
    cnt_clr[3] = 1'b1;
    tick();
    load[3] = 1'b0; cnt_clr[3] = 1'b0;
    chk("ch3_s4", 32'(state[11:9]), 32'd4);
    chk("ch3_cnt0", 32'(z_count[7:6]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("ch3_cnt%0d", i + 1), 32'(z_count[7:6]),
          32'(cexp[i]));
    end
    cnt_clr[3] = 1'b1;
    tick();
    chk("ch3_cclr", 32'(z_count[7:6]), 32'd0);
    cnt_clr[3] = 1'b0;
    tick();
    chk("ch3_resume", 32'(z_count[7:6]), 32'd1);

    // reset with pending loads
    load[2] = 1'b1; load_state[8:6] = 3'b111;
    tick();
    chk("pre_rst_err", 32'(err[2]), 32'd1);
    load = '1; load_state = {4{3'b011}};
    reset = 1'b1;
    tick();
    chk("mid_rst_state", 32'(state), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    chk("mid_rst_cnt", 32'(z_count), 32'h0);
    idle();
    tick();
    chk("post_rst_state", 32'(state), 32'h0);

    // random run against bench model
    for (int i = 0; i < NC; i++) begin
      ms[i] = 3'd0; me[i] = 1'b0; mc[i] = '0;
    end
    for (int c = 0; c < 10000; c++) begin
      en = NC'($urandom);
      x = NC'($urandom);
      for (int i = 0; i < NC; i++) begin
        load[i] = ($urandom_range(0, 7) == 0);
        cnt_clr[i] = ($urandom_range(0, 15) == 0);
      end
      load_state = (3*NC)'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NC; i++) begin
        ls = load_state[3*i +: 3];
        if (cnt_clr[i]) mc[i] = '0;
        else if ((ms[i] == 3'd3 || ms[i] == 3'd4) && mc[i] != 2'd3)
          mc[i] = mc[i] + 2'd1;
        if (load[i] && ls > 3'd4) me[i] = 1'b1;
        else if (err_clr) me[i] = 1'b0;
        if (load[i]) ms[i] = (ls > 3'd4) ? 3'd0 : ls;
        else if (en[i]) ms[i] = tnext(ms[i], x[i]);
      end
      tick();
      bad = 1'b0;
      for (int i = 0; i < NC; i++) begin
        es[3*i +: 3] = ms[i];
        ez[i] = (ms[i] == 3'd3) || (ms[i] == 3'd4);
        ee[i] = me[i];
        ec[CW*i +: CW] = mc[i];
        if (state[3*i +: 3] > 3'd4) bad = 1'b1;
      end
      chk("rnd_state", 32'(state), 32'(es));
      chk("rnd_z", 32'(z), 32'(ez));
      chk("rnd_err", 32'(err), 32'(ee));
      chk("rnd_cnt", 32'(z_count), 32'(ec));
      chk("rnd_legal", 32'(bad), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q3c_fsm_bank.md
# q3c_fsm_bank

Parametrised bank of NUM_CH independent, registered 5-state Moore machines built on the 3-bit y/x encoding of the single-channel q3c next-state logic. Each channel adds a state register, per-channel step enable, synchronous state load, illegal-code detection with a sticky error flag, and a saturating counter of z-high cycles. It sits beside the existing combinational next-state block and is used wherever several serial-bit detectors run in parallel on one clock.

## Interface
- NUM_CH, 4: number of independent channels (1..32)
- CNT_W, 8: width of each per-channel z-cycle counter (2..16)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; all channels to S0, flags and counters cleared
- en  in  NUM_CH  per-channel step enable; state advances only when high
- x  in  NUM_CH  per-channel serial input bit
- load  in  NUM_CH  per-channel synchronous state load strobe
- load_state  in  3*NUM_CH  load value, channel i at bits [3i+2:3i]
- err_clr  in  1  clears all err flags
- cnt_clr  in  NUM_CH  per-channel z_count clear
- state  out  3*NUM_CH  registered state, channel i at [3i+2:3i]
- z  out  NUM_CH  Moore output, decoded from registered state only
- err  out  NUM_CH  sticky illegal-load flag
- z_count  out  CNT_W*NUM_CH  saturating z-high cycle count, channel i at [CNT_W*i+CNT_W-1:CNT_W*i]

## Operation
- Legal states: S0=000, S1=001, S2=010, S3=011, S4=100. Codes 101..111 are illegal and must never reach the state register.
- Next state (x=0 / x=1): S0 -> S0/S1; S1 -> S1/S4; S2 -> S2/S1; S3 -> S1/S2; S4 -> S3/S4.
- z = 1 in S3 and S4, 0 in S0..S2.
- Per-channel state update priority: reset > load > en > hold.
  - load with legal code: state <= load_state (en/x ignored that cycle).
  - load with illegal code: state <= S0, err[i] set.
  - en=1, no load: state <= next(state, x).
  - otherwise state holds.
- err: set only by illegal load. err_clr clears all channels. If err_clr and an illegal load on channel i occur in the same cycle, err[i] ends at 1 (set wins).
- z_count[i]: each edge where z[i]=1 (pre-edge registered value), count +1, saturating at 2^CNT_W-1 (no wrap). cnt_clr[i] forces 0 and takes priority over increment. Counting is independent of en.
- Channels never interact; every per-channel rule applies independently.

## Timing
- Reset values: state=000 for all channels, z=0, err=0, z_count=0. Reset mid-operation discards any pending load/step the same cycle.
- State latency: one cycle from en/x/load sample to new state. z follows state combinationally with no path from x, en or load.
- z_count reflects z one cycle late: z high during cycle n -> count incremented at edge ending cycle n.
- err visible the cycle after the illegal load; the channel is in S0 that same cycle.
- No handshake; all inputs are sampled every rising edge.

## Structure
- Package q3c_fsm_pkg: state typedef (3-bit enum S0..S4), the S0..S4 constants, a next_state(state, x) function, a z_of(state) function, and an is_legal(code) function. The existing single-channel block and this one share the package.
- Sub-module q3c_fsm_ch: one channel (state register, err flag, z counter), instantiated NUM_CH times by generate. The top level only slices buses and fans out err_clr.

## Test plan
- Reset, then en=1 on ch0 with x sequence 1,1,0,0,1 -> state S1,S4,S3,S1,S4; z = 0,1,1,0,1 on the respective following cycles.
- ch1: load_state=011 with load=1 and en=1, x=1 in the same cycle -> state=S3 next cycle (load wins), z[1]=1; then en=1, x=0 -> S1.
- ch2: load_state=110 -> state=S0 and err[2]=1 next cycle; repeat illegal load concurrent with err_clr -> err[2] stays 1; err_clr alone -> err[2]=0.
- CNT_W=2, ch3 held in S4 (en=0) for 6 cycles -> z_count 1,2,3,3,3,3; cnt_clr[3] -> 0 next cycle, then resumes at 1.
- All channels in various states, assert reset for one cycle while loads are pending -> all state=000, err=0, z_count=0, loads discarded.
- Random en/x/load on all NUM_CH=4 channels for 10k cycles against a package-function model -> state, z, err, z_count match every cycle; state never 101..111.
